// File: rtl/mem_access_unit.sv
// Load/store requester for a single-port word memory in the MEM stage.
// Define SUBWORD_EN to build byte/half loads and read-modify-write sub-word stores.
module mem_access_unit #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [4:0]    req_rd,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic [4:0]    resp_rd,
    output logic          resp_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e state_q, state_d;

    logic          accept;
    logic          range_err;
    logic          size_err;
    logic          req_err;

    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] resp_rdata_q;
    logic [4:0]    resp_rd_q;
    logic          resp_err_q;

`ifdef SUBWORD_EN
    logic          we_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [1:0]    off_q;
    logic [DW-1:0] wdata_q;

    // Select the addressed lane and zero- or sign-extend it to a full word.
    function automatic logic [DW-1:0] lane_extract(input logic [DW-1:0] word,
                                                   input logic [1:0]    size,
                                                   input logic          sgn,
                                                   input logic [1:0]    off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SizeByte: lane_extract = {{24{sgn & b[7]}}, b};
            SizeHalf: lane_extract = {{16{sgn & h[15]}}, h};
            default:  lane_extract = word;
        endcase
    endfunction

    // Replace the addressed lane of the old word with the low bits of the store data.
    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] wdata,
                                                 input logic [1:0]    size,
                                                 input logic [1:0]    off);
        lane_merge = old;
        case (size)
            SizeByte: lane_merge[{off, 3'b000} +: 8]     = wdata[7:0];
            SizeHalf: lane_merge[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default:  lane_merge = wdata;
        endcase
    endfunction

    always_comb begin
        case (req_size)
            SizeByte: size_err = 1'b0;
            SizeHalf: size_err = req_addr[0];
            SizeWord: size_err = |req_addr[1:0];
            default:  size_err = 1'b1;
        endcase
    end
`else
    logic unused_signed;
    assign unused_signed = req_signed;

    assign size_err = (req_size != SizeWord) || (|req_addr[1:0]);
`endif

    assign accept    = req_valid && req_ready;
    assign range_err = (req_addr >> (AW + 2)) != 32'd0;
    assign req_err   = size_err || range_err;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_we && req_size == SizeWord) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                state_d = StResp;
`ifdef SUBWORD_EN
                if (we_q) begin
                    state_d = StWrite;
                end
`endif
            end
            StWrite: state_d = StResp;
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and memory strobe decoded from the state register only.
    always_comb begin
        req_ready  = rst_n && (state_q == StIdle);
        mem_we     = rst_n && (state_q == StWrite);
        resp_valid = (state_q == StResp);
    end

    // Request latch, memory drive and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
`ifdef SUBWORD_EN
            we_q         <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            off_q        <= '0;
            wdata_q      <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        mem_addr_q   <= req_addr[AW+1:2];
                        resp_rd_q    <= req_rd;
                        resp_err_q   <= req_err;
                        resp_rdata_q <= '0;
                        // Full-word stores go straight to WRITE, so stage the data now.
                        if (req_we && !req_err && req_size == SizeWord) begin
                            mem_wdata_q <= req_wdata;
                        end
`ifdef SUBWORD_EN
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        off_q    <= req_addr[1:0];
                        wdata_q  <= req_wdata;
`endif
                    end
                end
                StRead: begin
`ifdef SUBWORD_EN
                    if (we_q) begin
                        mem_wdata_q <= lane_merge(mem_rdata, wdata_q, size_q, off_q);
                    end else begin
                        resp_rdata_q <= lane_extract(mem_rdata, size_q, signed_q, off_q);
                    end
`else
                    resp_rdata_q <= mem_rdata;
`endif
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized traffic
// checked against a byte-lane reference model of the memory.
module tb_mem_access_unit;

    localparam int unsigned AW    = 5;
    localparam int unsigned Words = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [4:0]    req_rd;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic [4:0]    resp_rd;
    logic          resp_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(AW), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory: combinational read, write at the edge ending the WRITE cycle.
    logic [31:0]   mem [Words];
    logic [31:0]   ref_mem [Words];
    logic          preloaded = 1'b0;
    int            we_total = 0;
    logic [AW-1:0] we_addr_last = '0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < Words; i++) mem[i] <= (i >= 1 && i <= 8) ? i : 0;
            preloaded <= 1'b1;
        end else if (mem_we === 1'b1) begin
            mem[mem_addr] <= mem_wdata;
            we_total      <= we_total + 1;
            we_addr_last  <= mem_addr;
        end
    end

    int            cmp  = 0;
    int            errs = 0;
    logic [31:0]   g_rdata;
    logic          g_err;
    logic [4:0]    g_rd;
    logic [AW-1:0] g_waddr;
    int            g_lat;
    int            g_wr;
    logic [31:0]   e_rdata;
    logic          e_err;
    int            e_lat;
    int            e_wr;

    // Reference model: byte-addressed arithmetic over ref_mem.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          nbytes;
        int          idx;
        int          sh;
        logic [31:0] mask;
        logic [31:0] lane;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        e_err  = (size == 2'b11) || (addr >= 4 * Words) || (addr % nbytes != 0);
`ifndef SUBWORD_EN
        if (size != 2'b10) e_err = 1'b1;
`endif
        e_rdata = 32'd0;
        e_wr    = 0;
        if (e_err) begin
            e_lat = 1;
        end else begin
            idx  = addr / 4;
            sh   = 8 * (addr % 4);
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            if (!we) begin
                lane = (ref_mem[idx] >> sh) & mask;
                if (sgn && nbytes < 4 && lane[8*nbytes-1]) lane = lane | ~mask;
                e_rdata = lane;
                e_lat   = 2;
            end else begin
                ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
                e_wr  = 1;
                e_lat = (nbytes == 4) ? 2 : 3;
            end
        end
    endtask

    // Issue one request with resp_ready high; starts and ends just after a negedge.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd);
        int w0;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        resp_ready = 1'b1;
        w0 = we_total;
        @(posedge clk);
        g_lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            g_lat++;
        end while (resp_valid !== 1'b1 && g_lat < 8);
        g_rdata = resp_rdata;
        g_err   = resp_err;
        g_rd    = resp_rd;
        g_wr    = we_total - w0;
        g_waddr = we_addr_last;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        if ({resp_valid, resp_err, resp_rd} !== 7'd0) begin
            errs++; $display("FAIL reset_resp_ctl: got %b want 0", {resp_valid, resp_err, resp_rd});
        end
        cmp++;
        if ({resp_rdata, mem_wdata, mem_addr} !== '0) begin
            errs++; $display("FAIL reset_data: got %h %h %h want 0", resp_rdata, mem_wdata, mem_addr);
        end
        cmp++;
        if ({req_ready, mem_we} !== 2'b00) begin
            errs++; $display("FAIL reset_forced: got %b want 00", {req_ready, mem_we});
        end
        cmp++;
        rst_n = 1'b1;
        @(negedge clk);
        if (req_ready !== 1'b1) begin
            errs++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
        cmp++;
    endtask

    task automatic test_word_load;
        model(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 5'd7);
        if ({g_rdata, g_err, g_rd} !== {32'h2, 1'b0, 5'd7}) begin
            errs++; $display("FAIL load_word: got %h/%b/%0d want 2/0/7", g_rdata, g_err, g_rd);
        end
        cmp++;
        if (g_lat != 2 || g_wr != 0) begin
            errs++; $display("FAIL load_word_timing: got lat %0d we %0d want 2 0", g_lat, g_wr);
        end
        cmp++;
    endtask

    task automatic test_word_store;
        model(1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEAD_BEEF);
        run_txn(1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEAD_BEEF, 5'd3);
        if (g_wr != 1 || g_waddr !== 5'd3 || g_lat != 2) begin
            errs++; $display("FAIL store_word_we: got we %0d addr %0d lat %0d want 1 3 2",
                             g_wr, g_waddr, g_lat);
        end
        cmp++;
        if ({g_rdata, g_err} !== 33'd0 || mem[3] !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL store_word_result: got %h/%b mem %h want 0/0 deadbeef",
                             g_rdata, g_err, mem[3]);
        end
        cmp++;
        model(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 5'd4);
        if (g_rdata !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL load_after_store: got %h want deadbeef", g_rdata);
        end
        cmp++;
    endtask

`ifdef SUBWORD_EN
    task automatic test_subword;
        logic [1:0]  sz  [3] = '{2'b00, 2'b00, 2'b01};
        logic        sg  [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] ad  [3] = '{32'h0D, 32'h0D, 32'h0E};
        logic [31:0] exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_DEAD};
        model(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_0080);
        run_txn(1'b1, 2'b00, 1'b0, 32'h0D, 32'h1234_5680, 5'd1);
        if (mem[3] !== 32'hDEAD_80EF || g_lat != 3 || g_wr != 1) begin
            errs++; $display("FAIL store_byte: got mem %h lat %0d we %0d want dead80ef 3 1",
                             mem[3], g_lat, g_wr);
        end
        cmp++;
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, sz[i], sg[i], ad[i], 32'd0, 5'd2);
            if (g_rdata !== exp[i] || g_err !== 1'b0 || g_lat != 2) begin
                errs++; $display("FAIL load_sub_%0d: got %h err %b lat %0d want %h 0 2",
                                 i, g_rdata, g_err, g_lat, exp[i]);
            end
            cmp++;
        end
    endtask
`else
    task automatic test_subword;
        run_txn(1'b0, 2'b00, 1'b1, 32'h0D, 32'd0, 5'd2);
        if ({g_rdata, g_err} !== {32'd0, 1'b1} || g_lat != 1) begin
            errs++; $display("FAIL sub_load_rejected: got %h err %b lat %0d want 0 1 1",
                             g_rdata, g_err, g_lat);
        end
        cmp++;
        run_txn(1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFF_FFFF, 5'd2);
        if (g_err !== 1'b1 || g_wr != 0 || mem[3] !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL sub_store_rejected: got err %b we %0d mem %h want 1 0 deadbeef",
                             g_err, g_wr, mem[3]);
        end
        cmp++;
    endtask
`endif

    task automatic test_errors;
        logic [31:0] ad [2] = '{32'h06, 32'h80};
        for (int i = 0; i < 2; i++) begin
            run_txn(1'b0, 2'b10, 1'b0, ad[i], 32'd0, 5'd6);
            if ({g_rdata, g_err} !== {32'd0, 1'b1} || g_lat != 1 || g_wr != 0) begin
                errs++; $display("FAIL err_%h: got %h err %b lat %0d we %0d want 0 1 1 0",
                                 ad[i], g_rdata, g_err, g_lat, g_wr);
            end
            cmp++;
        end
    endtask

    task automatic test_backpressure;
        logic [37:0] snap;
        int          n;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr  = 32'h08; req_rd = 5'd9; resp_ready = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
        end while (resp_valid !== 1'b1 && n < 8);
        snap = {resp_rdata, resp_rd, resp_err};
        if (snap !== {32'h2, 5'd9, 1'b0}) begin
            errs++; $display("FAIL bp_resp: got %h want %h", snap, {32'h2, 5'd9, 1'b0});
        end
        cmp++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if ({resp_valid, req_ready, resp_rdata, resp_rd, resp_err} !== {2'b10, snap}) begin
                errs++; $display("FAIL bp_hold_%0d: got %b%b %h want 10 %h",
                                 k, resp_valid, req_ready, {resp_rdata, resp_rd, resp_err}, snap);
            end
            cmp++;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        if ({req_ready, resp_valid} !== 2'b10) begin
            errs++; $display("FAIL bp_release: got %b want 10", {req_ready, resp_valid});
        end
        cmp++;
    endtask

    task automatic test_reset_mid;
        int w0;
        w0 = we_total;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr  = 32'h11; req_wdata = 32'h55; req_rd = 5'd12;
`ifndef SUBWORD_EN
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
`endif
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        if ({req_ready, mem_we, resp_valid, resp_err, resp_rd, resp_rdata, mem_addr, mem_wdata}
                !== '0) begin
            errs++; $display("FAIL midreset_outputs: got %b%b%b%b %h %h %h %h want all 0",
                             req_ready, mem_we, resp_valid, resp_err, resp_rd, resp_rdata,
                             mem_addr, mem_wdata);
        end
        cmp++;
        rst_n = 1'b1;
        @(negedge clk);
        if (req_ready !== 1'b1 || we_total != w0 || mem[4] !== ref_mem[4]) begin
            errs++; $display("FAIL midreset_after: got ready %b writes %0d mem %h want 1 0 %h",
                             req_ready, we_total - w0, mem[4], ref_mem[4]);
        end
        cmp++;
    endtask

    task automatic test_random;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          r;
        int          bad;
        for (int t = 0; t < 80; t++) begin
            r     = $urandom_range(0, 7);
            size  = (r < 4) ? 2'b10 : 2'(r - 4);
            we    = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            rd    = 5'($urandom_range(0, 31));
            addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'b10) addr[1:0] = 2'b00;
                if (size == 2'b01) addr[0] = 1'b0;
            end
            model(we, size, sgn, addr, wdata);
            run_txn(we, size, sgn, addr, wdata, rd);
            if ({g_rdata, g_err, g_rd} !== {e_rdata, e_err, rd} || g_lat != e_lat || g_wr != e_wr)
                begin
                errs++; $display("FAIL rand_%0d we%b sz%b a%h: got %h/%b/%0d lat%0d w%0d want %h/%b/%0d lat%0d w%0d",
                                 t, we, size, addr, g_rdata, g_err, g_rd, g_lat, g_wr,
                                 e_rdata, e_err, rd, e_lat, e_wr);
            end
            cmp++;
            if (e_wr == 1 && g_waddr !== addr[6:2]) begin
                errs++; $display("FAIL rand_%0d_waddr: got %0d want %0d", t, g_waddr, addr[6:2]);
            end
            if (e_wr == 1) cmp++;
        end
        bad = 0;
        for (int i = 0; i < Words; i++) if (mem[i] !== ref_mem[i]) bad++;
        if (bad != 0) begin
            errs++; $display("FAIL rand_mem_image: got %0d differing words want 0", bad);
        end
        cmp++;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        resp_ready = 1'b1;
        for (int i = 0; i < Words; i++) ref_mem[i] = (i >= 1 && i <= 8) ? i : 0;
        test_reset;
        test_word_load;
        test_word_store;
        test_subword;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
